// File: rtl/axi_stream_dw_downsizer_pkg.sv
// axi_stream_dw_downsizer_pkg: state encoding, helpers and default stream types for the downsizer.
package axi_stream_dw_downsizer_pkg;
  typedef enum logic [1:0] {Idle = 2'd0, Emit = 2'd1} state_e;
  function automatic int unsigned max1(input int unsigned v);
    return v > 0 ? v : 1;
  endfunction
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [0:0]  id;
    logic [0:0]  dest;
    logic [0:0]  user;
  } axis_wide_t;
  typedef struct packed {
    logic       tvalid;
    axis_wide_t t;
  } axis_wide_req_t;
  typedef struct packed {
    logic [7:0] data;
    logic [0:0] strb;
    logic [0:0] keep;
    logic       last;
    logic [0:0] id;
    logic [0:0] dest;
    logic [0:0] user;
  } axis_narrow_t;
  typedef struct packed {
    logic         tvalid;
    axis_narrow_t t;
  } axis_narrow_req_t;
  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

// File: rtl/axi_stream_dw_downsizer_lzc.sv
// axi_stream_dw_downsizer_lzc: leading-zero count from the MSB; empty_o flags an all-zero input.
module axi_stream_dw_downsizer_lzc #(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = 2
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < Width; i++) cnt_o = in_i[i] ? CntW'(Width - 1 - i) : cnt_o;
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/axi_stream_dw_downsizer.sv
// axi_stream_dw_downsizer: splits each wide AXI Stream beat into narrow sub-beats, LSB slice first,
// optionally skipping the all-null tail of a tlast beat.
module axi_stream_dw_downsizer
  import axi_stream_dw_downsizer_pkg::*;
#(
  parameter int unsigned DataWidthIn  = 64,
  parameter int unsigned DataWidthOut = 8,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 0,
  parameter bit          DropNullTail = 1'b1,
  parameter type axi_stream_in_req_t  = axis_wide_req_t,
  parameter type axi_stream_in_rsp_t  = axis_rsp_t,
  parameter type axi_stream_out_req_t = axis_narrow_req_t,
  parameter type axi_stream_out_rsp_t = axis_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_in_req_t  in_req_i,
  output axi_stream_in_rsp_t  in_rsp_o,
  output axi_stream_out_req_t out_req_o,
  input  axi_stream_out_rsp_t out_rsp_i
);
  localparam int unsigned N       = DataWidthIn / DataWidthOut;
  localparam int unsigned CntW    = max1($clog2(N));
  localparam int unsigned StrbIn  = DataWidthIn / 8;
  localparam int unsigned StrbOut = DataWidthOut / 8;
  localparam int unsigned IdW     = max1(IdWidth);
  localparam int unsigned DestW   = max1(DestWidth);
  localparam int unsigned UserW   = max1(UserWidth);
  if (DataWidthIn <= DataWidthOut || DataWidthIn % DataWidthOut != 0 || DataWidthOut % 8 != 0) begin : g_bad_cfg
    $fatal(1, "axi_stream_dw_downsizer: invalid data width configuration");
  end
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d, last_idx_q, last_idx_d, lz;
  logic [DataWidthIn-1:0] data_q, data_d;
  logic [StrbIn-1:0]      strb_q, strb_d, keep_q, keep_d;
  logic                   last_q, last_d;
  logic [IdW-1:0]         id_q, id_d;
  logic [DestW-1:0]       dest_q, dest_d;
  logic [UserW-1:0]       user_q, user_d;
  logic [N-1:0]           nz;
  logic                   empty, fin, out_hs, in_rdy, cap;
  for (genvar k = 0; k < N; k++) begin : g_nz
    assign nz[k] = |in_req_i.t.keep[k*StrbOut +: StrbOut];
  end
  // Leading zeros of the non-null map give the highest sub-beat that still carries bytes.
  axi_stream_dw_downsizer_lzc #(.Width(N), .CntW(CntW)) i_lzc (
    .in_i   (nz),
    .cnt_o  (lz),
    .empty_o(empty)
  );
  assign fin    = cnt_q == last_idx_q;
  assign out_hs = state_q == Emit && out_rsp_i.tready;
  assign in_rdy = state_q == Idle || (out_hs && fin);
  assign cap    = in_rdy && in_req_i.tvalid;
  always_comb begin
    state_d    = cap ? Emit : (state_q == Emit && !(out_hs && fin)) ? Emit : Idle;
    cnt_d      = cap ? '0 : (out_hs && !fin) ? cnt_q + 1'b1 : cnt_q;
    last_idx_d = !cap ? last_idx_q :
                 (DropNullTail && in_req_i.t.last) ? (empty ? '0 : CntW'(N - 1) - lz) : CntW'(N - 1);
    data_d     = cap ? in_req_i.t.data : data_q;
    strb_d     = cap ? in_req_i.t.strb : strb_q;
    keep_d     = cap ? in_req_i.t.keep : keep_q;
    last_d     = cap ? in_req_i.t.last : last_q;
    id_d       = cap ? in_req_i.t.id : id_q;
    dest_d     = cap ? in_req_i.t.dest : dest_q;
    user_d     = cap ? in_req_i.t.user : user_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      cnt_q      <= '0;
      last_idx_q <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      id_q       <= '0;
      dest_q     <= '0;
      user_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      id_q       <= id_d;
      dest_q     <= dest_d;
      user_q     <= user_d;
    end
  end
  always_comb begin
    out_req_o        = '0;
    out_req_o.tvalid = state_q == Emit;
    out_req_o.t.data = data_q[32'(cnt_q)*DataWidthOut +: DataWidthOut];
    out_req_o.t.strb = strb_q[32'(cnt_q)*StrbOut +: StrbOut];
    out_req_o.t.keep = keep_q[32'(cnt_q)*StrbOut +: StrbOut];
    out_req_o.t.last = last_q && fin;
    out_req_o.t.id   = id_q;
    out_req_o.t.dest = dest_q;
    out_req_o.t.user = user_q;
    in_rsp_o         = '0;
    in_rsp_o.tready  = in_rdy;
  end
endmodule
